rom_port_arbiter: RTL and testbench
===================================

# rom_port_arbiter

Shares the single external program-ROM memory port (SDRAM controller read channel) between the main 68000 and the sound 68000. It consumes the decoded ROM chip selects and address strobes of both CPUs, runs one memory read at a time with a req/ack handshake, returns the 16-bit word to the owning CPU, and generates that CPU's DTACK. It sits between the address-decode block and the SDRAM controller.

## Interface
- `SND_BASE`, default 24'h080000: byte offset of sound ROM within the memory port address space.
- `DW`, default 16: data width.
- `clk` in 1: system clock; all state on rising edge.
- `reset` in 1: asynchronous, active-high.
- `m68kp_rom_cs` in 1: main CPU ROM select (decoded).
- `m68kp_as_n` in 1: main CPU address strobe, active low.
- `m68kp_a` in 24: main CPU byte address.
- `m68kp_rom_dout` out DW: word returned to main CPU.
- `m68kp_rom_dtack_n` out 1: main CPU DTACK, active low.
- `m68ks_rom_cs`, `m68ks_as_n`, `m68ks_a`, `m68ks_rom_dout`, `m68ks_rom_dtack_n`: same for sound CPU.
- `mem_req` out 1: read request, level, held until ack.
- `mem_addr` out 24: word-aligned byte address (bit 0 = 0).
- `mem_ack` in 1: one-cycle pulse; `mem_data` valid same cycle.
- `mem_data` in DW: read data.

## Operation
- Per port: `pend` set when `cs & !as_n` sampled and port neither pending nor done; `done` set when its data is returned; both clear when `as_n` sampled high.
- FSM states IDLE, BUSY_P, BUSY_S.
- IDLE: if main pending -> BUSY_P; else if sound pending -> BUSY_S. Transition edge registers `mem_req`=1 and `mem_addr` (main: `{m68kp_a[23:1],0}`; sound: `SND_BASE + {m68ks_a[23:1],0}`, 24-bit wrap).
- BUSY_x: on `mem_ack`, latch `mem_data` into `x_rom_dout`, set `done_x` unless `as_n_x` high, clear `pend_x`, drop `mem_req`, return IDLE.
- `dtack_n_x = !(done_x & !as_n_x)`, combinationally gated by `as_n` so it releases in the same cycle the strobe rises.
- Aborted cycle (`as_n` rises while BUSY): transaction runs to `mem_ack`, data discarded, no `done`.
- `mem_ack` in IDLE: ignored.
- No caching: every new strobe re-fetches even for the same address.

## Timing
- Reset values: `mem_req`=0, `mem_addr`=0, both `dout`=0, both `dtack_n`=1, FSM IDLE, `pend`/`done`=0, last-grant=sound.
- Strobe sampled at edge E0 -> `pend` after E0 -> `mem_req` high after E1.
- `mem_ack` sampled at Ek -> `dout` valid, `dtack_n` low, `mem_req` low after Ek. Minimum strobe-to-DTACK is 3 edges (ack on first `mem_req` cycle).
- Back-to-back: IDLE lasts at least one cycle between grants; `mem_req` is low for at least one cycle.
- Simultaneous pending: see Configuration; the loser is granted on the next IDLE.
- Asynchronous reset mid-transaction: outputs go to reset values immediately. A late `mem_ack` after reset is ignored.

## Configuration
- `ROM_ARB_RR_EN` defined: round-robin on ties. The port not granted last wins. The last-grant register updates on each grant.
- Not defined: fixed priority, main always wins ties. The last-grant register is not built.

## Structure
- Shared package `megasys1_pkg`:
  - FSM state enum (IDLE/BUSY_P/BUSY_S).
  - Port index constants (PORT_MAIN=0, PORT_SND=1).
  - Default `SND_BASE`.
- Sub-module `rom_arb_port`, instantiated twice, holds:
  - `pend`/`done` tracking;
  - `dout` register;
  - `dtack_n` generation.
- Top level holds the FSM, grant logic and memory-port registers.

## Test plan
- Single main read at 24'h001234, ack 2 cycles after `mem_req` with 16'hBEEF -> `mem_addr`=24'h001234; `m68kp_rom_dout`=16'hBEEF; `dtack_n` low until `as_n` high.
- Sound read at 24'h000100 -> `mem_addr`=24'h080100; only sound DTACK asserts.
- Both strobes on the same edge, fixed priority -> main granted first, sound second. With `ROM_ARB_RR_EN` and a preceding main grant -> sound first.
- Main `as_n` rises before `mem_ack` -> `mem_req` still completes, no DTACK; the next main strobe issues a fresh request.
- Assert `reset` while BUSY_S with `mem_req`=1 -> `mem_req`=0 and `dtack_n`=1 immediately. A following `mem_ack` pulse causes no DTACK.

Source files
------------

// File: rtl/megasys1_pkg.sv
// Shared definitions for the Mega System 1 ROM port arbiter slice:
// arbiter FSM states, port index constants and the default sound ROM offset.
package megasys1_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_P = 2'd1,
    BUSY_S = 2'd2
  } arbState_t;

  localparam logic PORT_MAIN = 1'b0;
  localparam logic PORT_SND  = 1'b1;

  localparam logic [23:0] SND_BASE_DEFAULT = 24'h080000;

  // The memory port only ever sees word-aligned byte addresses.
  function automatic logic [23:0] wordAddr(input logic [23:0] a);
    return {a[23:1], 1'b0};
  endfunction

endpackage

// File: rtl/rom_port_arbiter_if.sv
// Read channel towards the SDRAM controller: level request held until a
// one-cycle ack, with read data valid in the ack cycle.
interface rom_port_arbiter_if #(
  parameter int DW = 16
);
  logic          mem_req;
  logic [23:0]   mem_addr;
  logic          mem_ack;
  logic [DW-1:0] mem_data;

  modport master (
    output mem_req,
    output mem_addr,
    input  mem_ack,
    input  mem_data
  );

  modport slave (
    input  mem_req,
    input  mem_addr,
    output mem_ack,
    output mem_data
  );
endinterface

// File: rtl/rom_arb_port.sv
// One CPU side of the ROM arbiter: tracks whether the current bus cycle
// still needs a fetch (pend) or has been served (done), holds the returned
// word and produces the CPU's DTACK.
module rom_arb_port
  import megasys1_pkg::*;
#(
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_cs,
  input  logic          i_asN,
  input  logic          i_ack,
  input  logic [DW-1:0] i_data,
  output logic          o_pend,
  output logic [DW-1:0] o_dout,
  output logic          o_dtackN
);

  logic r_pend;
  logic r_done;
  logic [DW-1:0] r_dout;

  // Strobe release ends the bus cycle and wins over everything, so an
  // ack arriving after the CPU gave up is discarded without raising done.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pend <= 1'b0;
      r_done <= 1'b0;
      r_dout <= '0;
    end else if (i_asN) begin
      r_pend <= 1'b0;
      r_done <= 1'b0;
    end else if (i_ack) begin
      r_pend <= 1'b0;
      r_done <= 1'b1;
      r_dout <= i_data;
    end else if (i_cs && !r_pend && !r_done) begin
      r_pend <= 1'b1;
    end
  end

  // DTACK is gated by the live strobe so it releases in the same cycle
  // the CPU lifts AS, without waiting for done to clear.
  always_comb begin
    o_dtackN = !(r_done && !i_asN);
  end

  assign o_pend = r_pend;
  assign o_dout = r_dout;

endmodule

// File: rtl/rom_port_arbiter.sv
// Shares the program-ROM read channel between the main and sound 68000s.
// One read is in flight at a time; the owning CPU receives the word and its
// DTACK from its rom_arb_port instance.
// Build option: define ROM_ARB_RR_EN for round-robin on simultaneous
// requests; otherwise the main CPU always wins ties.
module rom_port_arbiter
  import megasys1_pkg::*;
#(
  parameter logic [23:0] SND_BASE = SND_BASE_DEFAULT,
  parameter int          DW       = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          m68kp_rom_cs,
  input  logic          m68kp_as_n,
  input  logic [23:0]   m68kp_a,
  output logic [DW-1:0] m68kp_rom_dout,
  output logic          m68kp_rom_dtack_n,
  input  logic          m68ks_rom_cs,
  input  logic          m68ks_as_n,
  input  logic [23:0]   m68ks_a,
  output logic [DW-1:0] m68ks_rom_dout,
  output logic          m68ks_rom_dtack_n,
  rom_port_arbiter_if.master mem
);

  arbState_t   r_state;
  arbState_t   w_stateNext;
  logic        w_pendMain;
  logic        w_pendSnd;
  logic        w_grantMain;
  logic        w_grantSnd;
  logic        w_ackMain;
  logic        w_ackSnd;
  logic        w_tieMain;
  logic        r_memReq;
  logic [23:0] r_memAddr;

  rom_arb_port #(.DW(DW)) u_portMain (
    .clk      (clk),
    .reset    (reset),
    .i_cs     (m68kp_rom_cs),
    .i_asN    (m68kp_as_n),
    .i_ack    (w_ackMain),
    .i_data   (mem.mem_data),
    .o_pend   (w_pendMain),
    .o_dout   (m68kp_rom_dout),
    .o_dtackN (m68kp_rom_dtack_n)
  );

  rom_arb_port #(.DW(DW)) u_portSnd (
    .clk      (clk),
    .reset    (reset),
    .i_cs     (m68ks_rom_cs),
    .i_asN    (m68ks_as_n),
    .i_ack    (w_ackSnd),
    .i_data   (mem.mem_data),
    .o_pend   (w_pendSnd),
    .o_dout   (m68ks_rom_dout),
    .o_dtackN (m68ks_rom_dtack_n)
  );

`ifdef ROM_ARB_RR_EN
  logic r_lastGrant;

  // Remember who was served last so a tie goes to the other CPU.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_lastGrant <= PORT_SND;
    end else if (w_grantMain) begin
      r_lastGrant <= PORT_MAIN;
    end else if (w_grantSnd) begin
      r_lastGrant <= PORT_SND;
    end
  end

  assign w_tieMain = (r_lastGrant == PORT_SND);
`else
  assign w_tieMain = 1'b1;
`endif

  // Grants only happen from IDLE, which forces at least one idle cycle
  // between transactions; an ack outside BUSY is simply ignored.
  always_comb begin
    w_stateNext = r_state;
    w_grantMain = 1'b0;
    w_grantSnd  = 1'b0;
    w_ackMain   = 1'b0;
    w_ackSnd    = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_pendMain && w_pendSnd) begin
          w_grantMain = w_tieMain;
          w_grantSnd  = !w_tieMain;
        end else if (w_pendMain) begin
          w_grantMain = 1'b1;
        end else if (w_pendSnd) begin
          w_grantSnd = 1'b1;
        end
        if (w_grantMain) begin
          w_stateNext = BUSY_P;
        end else if (w_grantSnd) begin
          w_stateNext = BUSY_S;
        end
      end
      BUSY_P: begin
        if (mem.mem_ack) begin
          w_ackMain   = 1'b1;
          w_stateNext = IDLE;
        end
      end
      BUSY_S: begin
        if (mem.mem_ack) begin
          w_ackSnd    = 1'b1;
          w_stateNext = IDLE;
        end
      end
      default: begin
        w_stateNext = IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // Request and address are registered on the grant edge and the request
  // drops on the ack edge; the address is left as-is between reads.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_memReq  <= 1'b0;
      r_memAddr <= '0;
    end else if (w_grantMain) begin
      r_memReq  <= 1'b1;
      r_memAddr <= wordAddr(m68kp_a);
    end else if (w_grantSnd) begin
      r_memReq  <= 1'b1;
      r_memAddr <= SND_BASE + wordAddr(m68ks_a);
    end else if (w_ackMain || w_ackSnd) begin
      r_memReq <= 1'b0;
    end
  end

  assign mem.mem_req  = r_memReq;
  assign mem.mem_addr = r_memAddr;

endmodule

// File: tb/tb_rom_port_arbiter.sv
// Directed bench for rom_port_arbiter with a transaction-level model that
// is checked against the DUT on every falling clock edge.
module tb_rom_port_arbiter;

  localparam logic [23:0] SNDB = 24'h080000;

  logic        clk;
  logic        reset;
  logic        pCs, pAsN, sCs, sAsN;
  logic [23:0] pA, sA;
  logic [15:0] pDout, sDout;
  logic        pDtackN, sDtackN;
  int          total;
  int          bad;
  bit          checkOn;

  rom_port_arbiter_if #(.DW(16)) memIf ();

  rom_port_arbiter #(.SND_BASE(SNDB), .DW(16)) dut (
    .clk               (clk),
    .reset             (reset),
    .m68kp_rom_cs      (pCs),
    .m68kp_as_n        (pAsN),
    .m68kp_a           (pA),
    .m68kp_rom_dout    (pDout),
    .m68kp_rom_dtack_n (pDtackN),
    .m68ks_rom_cs      (sCs),
    .m68ks_as_n        (sAsN),
    .m68ks_a           (sA),
    .m68ks_rom_dout    (sDout),
    .m68ks_rom_dtack_n (sDtackN),
    .mem               (memIf)
  );

  // Free-running 100 MHz clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [23:0] act, input logic [23:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h, wanted %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: mOwner is -1 when the memory port is free, else the CPU index
  // (0 main, 1 sound) whose read is in flight.
  int          mOwner;
  int          mLast;
  bit          mWant [2];
  bit          mServed [2];
  logic [15:0] mDout [2];
  logic [23:0] mAddr;

  // Advance the model by one clock using the inputs seen at the edge.
  always @(posedge clk or posedge reset) begin : modelBlk
    bit          asN [2];
    bit          cs [2];
    int          grant;
    int          fin;
    if (reset) begin
      mOwner = -1;
      mLast  = 1;
      mAddr  = 24'h0;
      for (int p = 0; p < 2; p++) begin
        mWant[p] = 0; mServed[p] = 0; mDout[p] = 16'h0;
      end
    end else begin
      asN[0] = pAsN; asN[1] = sAsN;
      cs[0]  = pCs;  cs[1]  = sCs;
      grant = -1;
      fin   = -1;
      if (mOwner < 0) begin
        if (mWant[0] && mWant[1]) begin
`ifdef ROM_ARB_RR_EN
          grant = (mLast == 0) ? 1 : 0;
`else
          grant = 0;
`endif
        end else if (mWant[0]) grant = 0;
        else if (mWant[1]) grant = 1;
      end else if (memIf.mem_ack) begin
        fin = mOwner;
      end
      for (int p = 0; p < 2; p++) begin
        if (asN[p]) begin
          mWant[p] = 0; mServed[p] = 0;
        end else if (fin == p) begin
          mWant[p] = 0; mServed[p] = 1; mDout[p] = memIf.mem_data;
        end else if (cs[p] && !mWant[p] && !mServed[p]) begin
          mWant[p] = 1;
        end
      end
      if (grant == 0) begin
        mOwner = 0; mLast = 0; mAddr = pA & 24'hFFFFFE;
      end else if (grant == 1) begin
        mOwner = 1; mLast = 1; mAddr = (SNDB + (sA & 24'hFFFFFE)) & 24'hFFFFFF;
      end else if (fin >= 0) begin
        mOwner = -1;
      end
    end
  end

  // Compare every DUT output against the model on each falling edge.
  always @(negedge clk) begin
    if (checkOn) begin
      checkOutput("mem_req",  {23'h0, memIf.mem_req}, {23'h0, (mOwner >= 0)});
      checkOutput("mem_addr", memIf.mem_addr, mAddr);
      checkOutput("dtack_p",  {23'h0, pDtackN}, {23'h0, !(mServed[0] && !pAsN)});
      checkOutput("dtack_s",  {23'h0, sDtackN}, {23'h0, !(mServed[1] && !sAsN)});
      checkOutput("dout_p",   {8'h0, pDout}, {8'h0, mDout[0]});
      checkOutput("dout_s",   {8'h0, sDout}, {8'h0, mDout[1]});
    end
  end

  task automatic applyStimulus(input bit port, input bit cs, input bit asN, input logic [23:0] a);
    if (port == 1'b0) begin
      pCs = cs; pAsN = asN; pA = a;
    end else begin
      sCs = cs; sAsN = asN; sA = a;
    end
  endtask

  // Bounded wait for the read request; a timeout shows up as a failed check.
  task automatic waitReq(input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!memIf.mem_req && n < 30);
    checkOutput(name, {23'h0, memIf.mem_req}, 24'h1);
  endtask

  // Ack sampled on the (gap+1)-th rising edge after the call.
  task automatic pulseAck(input logic [15:0] d, input int gap);
    repeat (gap) @(posedge clk);
    #1;
    memIf.mem_ack = 1'b1;
    memIf.mem_data = d;
    @(posedge clk);
    #1;
    memIf.mem_ack = 1'b0;
    memIf.mem_data = 16'h0;
  endtask

  task automatic releasePort(input bit port);
    @(posedge clk);
    #1;
    applyStimulus(port, 1'b0, 1'b1, 24'h0);
    #1;
    if (port == 1'b0) checkOutput("dtack_p_release", {23'h0, pDtackN}, 24'h1);
    else              checkOutput("dtack_s_release", {23'h0, sDtackN}, 24'h1);
    repeat (2) @(posedge clk);
  endtask

  task automatic singleRead(input bit port, input logic [23:0] a, input logic [23:0] expAddr,
                            input logic [15:0] d);
    @(posedge clk);
    #1;
    applyStimulus(port, 1'b1, 1'b0, a);
    waitReq("req_single");
    checkOutput("addr_single", memIf.mem_addr, expAddr);
    pulseAck(d, 1);
    @(negedge clk);
    if (port == 1'b0) begin
      checkOutput("dout_p_lit",  {8'h0, pDout}, {8'h0, d});
      checkOutput("dtack_p_lit", {23'h0, pDtackN}, 24'h0);
      checkOutput("dtack_s_idle", {23'h0, sDtackN}, 24'h1);
    end else begin
      checkOutput("dout_s_lit",  {8'h0, sDout}, {8'h0, d});
      checkOutput("dtack_s_lit", {23'h0, sDtackN}, 24'h0);
      checkOutput("dtack_p_idle", {23'h0, pDtackN}, 24'h1);
    end
    repeat (3) @(negedge clk);
    releasePort(port);
  endtask

  logic [23:0] firstAddr, secondAddr;
  logic [15:0] expPDout, expSDout;

  initial begin
    total = 0; bad = 0; checkOn = 0;
    reset = 1'b1;
    pCs = 0; pAsN = 1; pA = 24'h0;
    sCs = 0; sAsN = 1; sA = 24'h0;
    memIf.mem_ack = 1'b0;
    memIf.mem_data = 16'h0;
    @(posedge clk);
    checkOn = 1;
    @(negedge clk);
    checkOutput("rst_req",     {23'h0, memIf.mem_req}, 24'h0);
    checkOutput("rst_addr",    memIf.mem_addr, 24'h0);
    checkOutput("rst_dtack_p", {23'h0, pDtackN}, 24'h1);
    checkOutput("rst_dtack_s", {23'h0, sDtackN}, 24'h1);
    @(posedge clk);
    #1 reset = 1'b0;
    repeat (2) @(posedge clk);

    singleRead(1'b0, 24'h001234, 24'h001234, 16'hBEEF);
    singleRead(1'b1, 24'h000100, 24'h080100, 16'hCAFE);
    singleRead(1'b0, 24'h000457, 24'h000456, 16'h0457);

`ifdef ROM_ARB_RR_EN
    firstAddr = 24'h080040; secondAddr = 24'h002000;
    expPDout = 16'h2222; expSDout = 16'h1111;
`else
    firstAddr = 24'h002000; secondAddr = 24'h080040;
    expPDout = 16'h1111; expSDout = 16'h2222;
`endif
    @(posedge clk);
    #1;
    applyStimulus(1'b0, 1'b1, 1'b0, 24'h002000);
    applyStimulus(1'b1, 1'b1, 1'b0, 24'h000040);
    waitReq("req_tie1");
    checkOutput("tie_first_addr", memIf.mem_addr, firstAddr);
    pulseAck(16'h1111, 0);
    @(negedge clk);
    checkOutput("tie_gap_req", {23'h0, memIf.mem_req}, 24'h0);
    waitReq("req_tie2");
    checkOutput("tie_second_addr", memIf.mem_addr, secondAddr);
    pulseAck(16'h2222, 0);
    @(negedge clk);
    checkOutput("tie_dout_p", {8'h0, pDout}, {8'h0, expPDout});
    checkOutput("tie_dout_s", {8'h0, sDout}, {8'h0, expSDout});
    releasePort(1'b0);
    releasePort(1'b1);

    @(posedge clk);
    #1;
    applyStimulus(1'b0, 1'b1, 1'b0, 24'h003000);
    waitReq("req_abort");
    @(posedge clk);
    #1;
    applyStimulus(1'b0, 1'b0, 1'b1, 24'h003000);
    pulseAck(16'h1234, 1);
    @(negedge clk);
    checkOutput("abort_dtack", {23'h0, pDtackN}, 24'h1);
    checkOutput("abort_req",   {23'h0, memIf.mem_req}, 24'h0);
    singleRead(1'b0, 24'h003000, 24'h003000, 16'h5A5A);

    @(posedge clk);
    #1;
    applyStimulus(1'b1, 1'b1, 1'b0, 24'h000200);
    waitReq("req_reset");
    checkOutput("reset_pre_addr", memIf.mem_addr, 24'h080200);
    #2 reset = 1'b1;
    #1;
    checkOutput("reset_req_now",   {23'h0, memIf.mem_req}, 24'h0);
    checkOutput("reset_dtack_now", {23'h0, sDtackN}, 24'h1);
    applyStimulus(1'b1, 1'b0, 1'b1, 24'h0);
    @(posedge clk);
    #1 reset = 1'b0;
    pulseAck(16'hDEAD, 0);
    @(negedge clk);
    checkOutput("late_ack_dtack", {23'h0, sDtackN}, 24'h1);
    checkOutput("late_ack_req",   {23'h0, memIf.mem_req}, 24'h0);
    repeat (3) @(posedge clk);

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
